// File: rtl/dtag_pkg.sv
// Shared types and widths for the dcache tag RAM arbiter.
// Requester encoding and per-requester write-operand bundle.
package dtag_pkg;

    localparam int IDX_W = 8;
    localparam int TAG_W = 21;
    localparam int THR_W = 2;
    localparam int AGE_W = 3;

    typedef enum logic [2:0] {
        REQ_L2   = 3'd0,
        REQ_MEM  = 3'd1,
        REQ_DCW  = 3'd2,
        REQ_DCR  = 3'd3,
        REQ_NONE = 3'd4
    } req_sel_e;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic [TAG_W-1:0] tag;
        logic [THR_W-1:0] thread;
        logic             way;
        logic             dirty;
    } wr_op_t;

    function automatic logic is_write(input req_sel_e sel);
        return (sel == REQ_L2) || (sel == REQ_MEM) || (sel == REQ_DCW);
    endfunction

endpackage

// File: rtl/dtag_prio_enc.sv
// Purpose: 4-way fixed priority pick, l2 > mem > dcw > dcr, or dcw > dcr > l2 > mem when promoted.
// Latency: combinational.
// Backpressure: none; losers simply see no selection.
module dtag_prio_enc
    import dtag_pkg::*;
(
    input  logic [3:0] req,
    input  logic       promote,
    output req_sel_e   sel
);

    // req bit order: [0]=l2 [1]=mem [2]=dcw [3]=dcr
    always_comb begin
        sel = REQ_NONE;
        if (promote && req[2])
            sel = REQ_DCW;
        else if (promote && req[3])
            sel = REQ_DCR;
        else if (req[0])
            sel = REQ_L2;
        else if (req[1])
            sel = REQ_MEM;
        else if (req[2])
            sel = REQ_DCW;
        else if (req[3])
            sel = REQ_DCR;
    end

endmodule

// File: rtl/dtag_arbiter.sv
// Purpose: single-port dcache tag RAM arbiter; DTAG_AGING_EN adds dcache anti-starvation aging.
// Latency: grant and RAM strobes same cycle; rd_valid one cycle after a dcr grant.
// Backpressure: requester holds req/operands until gnt; dropping req withdraws it.
module dtag_arbiter
    import dtag_pkg::*;
#(
    parameter int AGE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             l2_req,
    input  logic             mem_req,
    input  logic             dcw_req,
    input  logic             dcr_req,

    input  logic [IDX_W-1:0] l2_index,
    input  logic [IDX_W-1:0] mem_index,
    input  logic [IDX_W-1:0] dcw_index,
    input  logic [IDX_W-1:0] dcr_index,

    input  logic [TAG_W-1:0] l2_tag,
    input  logic [TAG_W-1:0] mem_tag,
    input  logic [TAG_W-1:0] dcw_tag,

    input  logic [THR_W-1:0] l2_thread,
    input  logic [THR_W-1:0] mem_thread,
    input  logic [THR_W-1:0] dcw_thread,

    input  logic             l2_way,
    input  logic             mem_way,
    input  logic             dcw_way,

    output logic             l2_gnt,
    output logic             mem_gnt,
    output logic             dcw_gnt,
    output logic             dcr_gnt,

    output logic [IDX_W-1:0] ram_index,
    output logic [TAG_W-1:0] ram_tag_wd,
    output logic [THR_W-1:0] ram_thread_wd,
    output logic             ram_dirty_wd,
    output logic             ram_block0_we,
    output logic             ram_block1_we,
    output logic             ram_block0_re,
    output logic             ram_block1_re,

    output logic             rd_valid,
    output logic [IDX_W-1:0] rd_index
);

    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);

    logic [3:0] req_vec;
    logic       promote;
    req_sel_e   sel;
    wr_op_t     l2_op;
    wr_op_t     mem_op;
    wr_op_t     dcw_op;
    wr_op_t     wop;
    logic       wr_en;
    logic       rd_en;

    // Reset masks all requests so nothing is granted while rst is high.
    assign req_vec = {dcr_req, dcw_req, mem_req, l2_req} & {4{~rst}};

    dtag_prio_enc u_prio_enc (
        .req     (req_vec),
        .promote (promote),
        .sel     (sel)
    );

`ifdef DTAG_AGING_EN
    logic [AGE_W-1:0] age;
    logic             dc_pending;
    logic             dc_granted;

    assign dc_pending = dcw_req | dcr_req;
    assign dc_granted = (sel == REQ_DCW) | (sel == REQ_DCR);

    always_ff @(posedge clk) begin
        if (rst)
            age <= '0;
        else if (dc_granted || !dc_pending)
            age <= '0;
        else if (age != AGE_LIM)
            age <= age + 1'b1;
    end

    assign promote = (age == AGE_LIM);
`else
    logic unused_age_cfg;
    assign unused_age_cfg = ^AGE_LIM;
    assign promote        = 1'b0;
`endif

    assign l2_op  = '{index: l2_index,  tag: l2_tag,  thread: l2_thread,  way: l2_way,  dirty: 1'b0};
    assign mem_op = '{index: mem_index, tag: mem_tag, thread: mem_thread, way: mem_way, dirty: 1'b0};
    assign dcw_op = '{index: dcw_index, tag: dcw_tag, thread: dcw_thread, way: dcw_way, dirty: 1'b1};

    always_comb begin
        wop   = '0;
        rd_en = 1'b0;
        unique case (sel)
            REQ_L2:  wop   = l2_op;
            REQ_MEM: wop   = mem_op;
            REQ_DCW: wop   = dcw_op;
            REQ_DCR: rd_en = 1'b1;
            default: wop   = '0;
        endcase
    end

    assign wr_en = is_write(sel);

    assign l2_gnt  = (sel == REQ_L2);
    assign mem_gnt = (sel == REQ_MEM);
    assign dcw_gnt = (sel == REQ_DCW);
    assign dcr_gnt = rd_en;

    // Idle cycles present the dcr address so a lookup index is always on the bus.
    assign ram_index     = rst ? '0 : (wr_en ? wop.index : dcr_index);
    assign ram_tag_wd    = wop.tag;
    assign ram_thread_wd = wop.thread;
    assign ram_dirty_wd  = wop.dirty;
    assign ram_block0_we = wr_en & ~wop.way;
    assign ram_block1_we = wr_en &  wop.way;
    assign ram_block0_re = rd_en;
    assign ram_block1_re = rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_index <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_index <= dcr_index;
        end
    end

endmodule

// File: tb/tb_dtag_arbiter.sv
// Directed bench for dtag_arbiter: vector table for single-cycle grants plus
// hand sequences for read latency, aging, and reset behaviour.
module tb_dtag_arbiter;
    import dtag_pkg::*;

    localparam int AGE_MAX = 4;
`ifdef DTAG_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic clk;
    logic rst;
    logic l2_req, mem_req, dcw_req, dcr_req;
    logic [7:0] l2_index, mem_index, dcw_index, dcr_index;
    logic [20:0] l2_tag, mem_tag, dcw_tag;
    logic [1:0] l2_thread, mem_thread, dcw_thread;
    logic l2_way, mem_way, dcw_way;
    logic l2_gnt, mem_gnt, dcw_gnt, dcr_gnt;
    logic [7:0] ram_index;
    logic [20:0] ram_tag_wd;
    logic [1:0] ram_thread_wd;
    logic ram_dirty_wd;
    logic ram_block0_we, ram_block1_we, ram_block0_re, ram_block1_re;
    logic rd_valid;
    logic [7:0] rd_index;

    logic [3:0] gnts;
    logic [3:0] strb;
    assign gnts = {dcr_gnt, dcw_gnt, mem_gnt, l2_gnt};
    assign strb = {ram_block1_re, ram_block0_re, ram_block1_we, ram_block0_we};

    int total = 0;
    int bad   = 0;

    dtag_arbiter #(.AGE_MAX(AGE_MAX)) dut (
        .clk(clk), .rst(rst),
        .l2_req(l2_req), .mem_req(mem_req), .dcw_req(dcw_req), .dcr_req(dcr_req),
        .l2_index(l2_index), .mem_index(mem_index), .dcw_index(dcw_index), .dcr_index(dcr_index),
        .l2_tag(l2_tag), .mem_tag(mem_tag), .dcw_tag(dcw_tag),
        .l2_thread(l2_thread), .mem_thread(mem_thread), .dcw_thread(dcw_thread),
        .l2_way(l2_way), .mem_way(mem_way), .dcw_way(dcw_way),
        .l2_gnt(l2_gnt), .mem_gnt(mem_gnt), .dcw_gnt(dcw_gnt), .dcr_gnt(dcr_gnt),
        .ram_index(ram_index), .ram_tag_wd(ram_tag_wd), .ram_thread_wd(ram_thread_wd),
        .ram_dirty_wd(ram_dirty_wd),
        .ram_block0_we(ram_block0_we), .ram_block1_we(ram_block1_we),
        .ram_block0_re(ram_block0_re), .ram_block1_re(ram_block1_re),
        .rd_valid(rd_valid), .rd_index(rd_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // The tag RAM is single-ported: at most one grant in any cycle.
    always @(negedge clk) begin
        total++;
        if ($countones(gnts) > 1) begin
            bad++;
            $display("FAIL onehot_gnt: got %b want at most one bit", gnts);
        end
    end

    task automatic set_req(input logic [3:0] r, input logic [2:0] w);
        {dcr_req, dcw_req, mem_req, l2_req} = r;
        {dcw_way, mem_way, l2_way} = w;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [3:0]  req;     // {dcr,dcw,mem,l2}
        logic [2:0]  ways;    // {dcw,mem,l2}
        logic [3:0]  e_gnt;   // {dcr,dcw,mem,l2}
        logic [7:0]  e_idx;
        logic [20:0] e_tag;
        logic [1:0]  e_thr;
        logic        e_dirty;
        logic [3:0]  e_strb;  // {re1,re0,we1,we0}
        logic        e_rdv;
    } vec_t;

    vec_t vt[9];

    initial begin
        rst = 1'b1;
        set_req(4'b0000, 3'b000);
        l2_index  = 8'h11; l2_tag  = 21'h0AAAAA; l2_thread  = 2'd1;
        mem_index = 8'h22; mem_tag = 21'h155555; mem_thread = 2'd3;
        dcw_index = 8'h33; dcw_tag = 21'h1ABCDE; dcw_thread = 2'd2;
        dcr_index = 8'h3A;

        vt[0] = '{"l2_dcw_w0",   4'b0101, 3'b000, 4'b0001, 8'h11, 21'h0AAAAA, 2'd1, 1'b0, 4'b0001, 1'b0};
        vt[1] = '{"l2_dcw_w1",   4'b0101, 3'b001, 4'b0001, 8'h11, 21'h0AAAAA, 2'd1, 1'b0, 4'b0010, 1'b0};
        vt[2] = '{"dcr_only",    4'b1000, 3'b000, 4'b1000, 8'h3A, 21'h000000, 2'd0, 1'b0, 4'b1100, 1'b1};
        vt[3] = '{"dcw_w1",      4'b0100, 3'b100, 4'b0100, 8'h33, 21'h1ABCDE, 2'd2, 1'b1, 4'b0010, 1'b0};
        vt[4] = '{"mem_dcw_dcr", 4'b1110, 3'b010, 4'b0010, 8'h22, 21'h155555, 2'd3, 1'b0, 4'b0010, 1'b0};
        vt[5] = '{"dcw_dcr",     4'b1100, 3'b000, 4'b0100, 8'h33, 21'h1ABCDE, 2'd2, 1'b1, 4'b0001, 1'b0};
        vt[6] = '{"idle",        4'b0000, 3'b111, 4'b0000, 8'h3A, 21'h000000, 2'd0, 1'b0, 4'b0000, 1'b0};
        vt[7] = '{"all_four",    4'b1111, 3'b111, 4'b0001, 8'h11, 21'h0AAAAA, 2'd1, 1'b0, 4'b0010, 1'b0};
        vt[8] = '{"mem_only",    4'b0010, 3'b000, 4'b0010, 8'h22, 21'h155555, 2'd3, 1'b0, 4'b0001, 1'b0};

        // Reset state with every request asserted.
        set_req(4'b1111, 3'b111);
        @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnts), 32'h0);
        chk("rst_strb", 32'(strb), 32'h0);
        chk("rst_ram_index", 32'(ram_index), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_rd_index", 32'(rd_index), 32'h0);
        set_req(4'b0000, 3'b000);
        #1 rst = 1'b0;

        // Table vectors, each from a fresh reset so arbitration state is clean.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            set_req(vt[i].req, vt[i].ways);
            @(negedge clk);
            chk({vt[i].name, "_gnt"},   32'(gnts),          32'(vt[i].e_gnt));
            chk({vt[i].name, "_idx"},   32'(ram_index),     32'(vt[i].e_idx));
            chk({vt[i].name, "_tag"},   32'(ram_tag_wd),    32'(vt[i].e_tag));
            chk({vt[i].name, "_thr"},   32'(ram_thread_wd), 32'(vt[i].e_thr));
            chk({vt[i].name, "_dirty"}, 32'(ram_dirty_wd),  32'(vt[i].e_dirty));
            chk({vt[i].name, "_strb"},  32'(strb),          32'(vt[i].e_strb));
            @(posedge clk);
            #1 set_req(4'b0000, 3'b000);
            @(negedge clk);
            chk({vt[i].name, "_rdv"}, 32'(rd_valid), 32'(vt[i].e_rdv));
            if (vt[i].e_rdv)
                chk({vt[i].name, "_rdidx"}, 32'(rd_index), 32'h3A);
        end

        // Back-to-back reads, then a same-index write right after the last read.
        do_reset();
        dcr_index = 8'h40;
        set_req(4'b1000, 3'b000);
        @(negedge clk);
        chk("b2b_gnt0", 32'(dcr_gnt), 32'h1);
        @(posedge clk);
        #1 dcr_index = 8'h41;
        @(negedge clk);
        chk("b2b_gnt1", 32'(dcr_gnt), 32'h1);
        chk("b2b_rdv0", 32'(rd_valid), 32'h1);
        chk("b2b_rdidx0", 32'(rd_index), 32'h40);
        @(posedge clk);
        #1 l2_index = 8'h41;
        set_req(4'b0001, 3'b000);
        @(negedge clk);
        chk("raw_l2_gnt", 32'(gnts), 32'h1);
        chk("raw_idx", 32'(ram_index), 32'h41);
        chk("raw_strb", 32'(strb), 32'b0001);
        chk("b2b_rdv1", 32'(rd_valid), 32'h1);
        chk("b2b_rdidx1", 32'(rd_index), 32'h41);
        @(posedge clk);
        #1 set_req(4'b0000, 3'b000);
        l2_index = 8'h11;
        @(negedge clk);
        chk("b2b_rdv_end", 32'(rd_valid), 32'h0);

        // l2 held six cycles against dcw; dcw drops its request once served.
        do_reset();
        set_req(4'b0101, 3'b000);
        for (int c = 1; c <= 6; c++) begin
            automatic logic e_dcw = AGING && (c == AGE_MAX + 1);
            @(negedge clk);
            chk($sformatf("age_c%0d_dcw", c), 32'(dcw_gnt), 32'(e_dcw));
            chk($sformatf("age_c%0d_l2", c), 32'(l2_gnt), 32'(!e_dcw));
            @(posedge clk);
            #1 if (e_dcw) dcw_req = 1'b0;
        end

        // All four requesters for four cycles: l2 wins every time.
        do_reset();
        set_req(4'b1111, 3'b000);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("all4_c%0d", c), 32'(gnts), 32'b0001);
            @(posedge clk);
            #1;
        end

        // Reset mid-run must clear accumulated age.
        do_reset();
        set_req(4'b0101, 3'b000);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("agerst_gnt", 32'(gnts), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 1; c <= AGE_MAX + 1; c++) begin
            automatic logic e_dcw = AGING && (c == AGE_MAX + 1);
            @(negedge clk);
            chk($sformatf("agerst_c%0d_dcw", c), 32'(dcw_gnt), 32'(e_dcw));
            @(posedge clk);
            #1;
        end
        set_req(4'b0000, 3'b000);

        // Reset the cycle after a dcr grant cancels its rd_valid; dcr re-granted after.
        do_reset();
        dcr_index = 8'h5C;
        set_req(4'b1000, 3'b000);
        @(negedge clk);
        chk("rstrd_gnt", 32'(dcr_gnt), 32'h1);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstrd_rdv", 32'(rd_valid), 32'h0);
        chk("rstrd_rdidx", 32'(rd_index), 32'h0);
        chk("rstrd_gnt_low", 32'(gnts), 32'h0);
        chk("rstrd_strb", 32'(strb), 32'h0);
        chk("rstrd_idx", 32'(ram_index), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstrd_regnt", 32'(gnts), 32'b1000);
        chk("rstrd_regnt_idx", 32'(ram_index), 32'h5C);
        @(posedge clk);
        #1 set_req(4'b0000, 3'b000);
        @(negedge clk);
        chk("rstrd_rdv2", 32'(rd_valid), 32'h1);
        chk("rstrd_rdidx2", 32'(rd_index), 32'h5C);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dtag_arbiter.md
DTAG_ARBITER -- requirements
Module: dtag_arbiter

Interface
REQ-001 Parameter AGE_MAX, default 4, cycles a pending dcache request may lose before it is promoted.
REQ-002 clk  input  1  clock; single clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 l2_req / mem_req / dcw_req / dcr_req  input  1 each  request: L2 refill write, memory refill write, dcache store write, dcache tag lookup.
REQ-005 l2_index / mem_index / dcw_index / dcr_index  input  8 each  set index per requester.
REQ-006 l2_tag / mem_tag / dcw_tag  input  21 each  tag write data.
REQ-007 l2_thread / mem_thread / dcw_thread  input  2 each  owning thread.
REQ-008 l2_way / mem_way / dcw_way  input  1 each  target way (0 = block0, 1 = block1).
REQ-009 l2_gnt / mem_gnt / dcw_gnt / dcr_gnt  output  1 each  one-cycle grant pulse.
REQ-010 ram_index  output  8  tag RAM address.
REQ-011 ram_tag_wd  output  21; ram_thread_wd  output  2; ram_dirty_wd  output  1  tag RAM write data.
REQ-012 ram_block0_we / ram_block1_we / ram_block0_re / ram_block1_re  output  1 each  tag RAM strobes.
REQ-013 rd_valid  output  1  tag RAM read data valid this cycle; rd_index  output  8  index of that read.

Function
REQ-014 Tag RAM is single-ported; exactly zero or one requester SHALL be granted per cycle.
REQ-015 Normal priority SHALL be l2 > mem > dcw > dcr.
REQ-016 A requester SHALL hold req and its operands stable until its gnt; deasserting req before gnt withdraws it without error.
REQ-017 gnt SHALL be combinational from current reqs and registered arbitration state; RAM address, data and strobes SHALL be driven in the grant cycle.
REQ-018 Write grant: blockN_we asserted for way N only; dirty_wd = 0 for l2/mem, 1 for dcw; all re low.
REQ-019 Read grant (dcr): both block0_re and block1_re asserted, index = dcr_index, all we low.
REQ-020 No grant: all strobes low; ram_index = dcr_index; tag/thread/dirty data 0.
REQ-021 rd_valid SHALL assert exactly one cycle after a dcr grant, with rd_index registered from the granted dcr_index.
REQ-022 Back-to-back dcr grants SHALL yield rd_valid on consecutive cycles.
REQ-023 Age counter (3 bits, saturating at AGE_MAX): increments each cycle dcw_req or dcr_req is high and neither is granted; clears on any dcw/dcr grant or when both are low.
REQ-024 When age == AGE_MAX, dcw then dcr SHALL take priority over l2 and mem for that cycle; counter then clears.
REQ-025 Same-index write granted the cycle after a dcr grant is legal; rd_valid data reflects pre-write contents (no forwarding).

Reset
REQ-026 While rst is high: all gnt, strobes, rd_valid low; rd_index 0; age 0; ram_index 0.
REQ-027 Reset asserted mid-operation SHALL cancel a pending rd_valid; requests are re-arbitrated from the first cycle after rst falls.

Configuration
REQ-028 Macro DTAG_AGING_EN: defined -> REQ-023/REQ-024 active; undefined -> age counter absent, fixed priority only, dcache may starve.

Structure
REQ-029 Shared package: requester encoding (REQ_L2, REQ_MEM, REQ_DCW, REQ_DCR, REQ_NONE), index/tag/thread widths (8/21/2).
REQ-030 One sub-module dtag_prio_enc: 4-input fixed priority encoder with a promote input; arbiter instantiates it once.

Verification
REQ-031 l2_req and dcw_req both high, age 0 -> l2_gnt=1, ram_block{l2_way}_we=1, dirty_wd=0; dcw_gnt=0.
REQ-032 dcr_req index 0x3A, no other reqs -> dcr_gnt, both re high; next cycle rd_valid=1, rd_index=0x3A.
REQ-033 l2_req held high 6 cycles with dcw_req high, AGE_MAX=4, DTAG_AGING_EN defined -> dcw_gnt in cycle 5, l2 regranted cycle 6; undefined -> dcw never granted.
REQ-034 dcw_req way 1, tag 0x1ABCDE, thread 2 -> ram_block1_we=1, tag_wd=0x1ABCDE, thread_wd=2, dirty_wd=1.
REQ-035 dcr granted, rst asserted next cycle -> rd_valid=0, age=0, all outputs at reset values.
REQ-036 All four reqs high 4 cycles, aging off -> grants l2 each cycle; exactly one gnt per cycle checked by assertion.
